pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, program-counter width in bits (8..32).
REQ-002 SHALL have parameter RESET_ADDR, default 0, value loaded into pc on reset.
REQ-003 SHALL have parameter STACK_DEPTH, default 4, return-address stack entries (power of two, 2..16).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port inc  input  2  increment amount 0..3 applied when no other operation is selected.
REQ-007 SHALL have port load  input  1  absolute load from load_addr.
REQ-008 SHALL have port load_addr  input  WIDTH  absolute load target.
REQ-009 SHALL have port call  input  1  push pc onto stack and jump to call_addr.
REQ-010 SHALL have port call_addr  input  WIDTH  call target.
REQ-011 SHALL have port ret  input  1  pop stack top into pc.
REQ-012 SHALL have port branch  input  1  relative branch.
REQ-013 SHALL have port offset  input  8  two's-complement branch displacement.
REQ-014 SHALL have port clear_err  input  1  clears sticky error flags.
REQ-015 SHALL have port pc  output  WIDTH  current counter value.
REQ-016 SHALL have port carry  output  1  combinational: increment path selected and pc + inc exceeds 2^WIDTH-1.
REQ-017 SHALL have port page_cross  output  1  registered one-cycle pulse: last branch changed pc[WIDTH-1:8].
REQ-018 SHALL have port stack_empty  output  1  stack holds zero entries.
REQ-019 SHALL have port stack_full  output  1  stack holds STACK_DEPTH entries.
REQ-020 SHALL have port overflow  output  1  sticky: call attempted while full.
REQ-021 SHALL have port underflow  output  1  sticky: ret attempted while empty.

Function
REQ-022 SHALL select one operation per cycle, priority load > call > ret > branch > increment.
REQ-023 SHALL on load set pc <= load_addr next edge.
REQ-024 SHALL on call, if not full, write current pc to stack[sp], sp <= sp+1, pc <= call_addr.
REQ-025 SHALL on call while full still set pc <= call_addr, discard push, leave sp and stack unchanged, set overflow.
REQ-026 SHALL on ret, if not empty, set pc <= stack[sp-1], sp <= sp-1.
REQ-027 SHALL on ret while empty hold pc unchanged, leave sp unchanged, set underflow.
REQ-028 SHALL on branch set pc <= pc + sign-extended offset, modulo 2^WIDTH.
REQ-029 SHALL assert page_cross for exactly the cycle after a branch whose result upper bits (WIDTH-1:8) differ from the pre-branch pc; otherwise deassert it.
REQ-030 SHALL on increment path set pc <= (pc + inc) modulo 2^WIDTH; inc=0 holds pc.
REQ-031 SHALL drive carry low whenever any of load, call, ret, branch is asserted.
REQ-032 SHALL ignore lower-priority requests in the same cycle entirely (no push/pop side effects from masked call/ret).
REQ-033 SHALL hold sp in a counter of width log2(STACK_DEPTH)+1; stack_empty = (sp==0), stack_full = (sp==STACK_DEPTH).
REQ-034 SHALL clear overflow and underflow on clear_err; a same-cycle set event takes priority over clear_err.
REQ-035 SHALL have zero-cycle output latency: pc, flags reflect registered state directly.

Reset
REQ-036 SHALL on reset_n low, asynchronously set pc=RESET_ADDR, sp=0, page_cross=0, overflow=0, underflow=0.
REQ-037 SHALL not require stack storage contents to be reset; entries are invalid while sp excludes them.
REQ-038 SHALL abort any in-flight operation when reset asserts mid-cycle; first post-release edge performs the operation then presented.

Verification
REQ-039 SHALL verify: reset, inc=1 for 3 cycles, then inc=3 -> pc 0x0000,0x0001,0x0002,0x0003,0x0006.
REQ-040 SHALL verify: pc=0xFFFE, inc=2 -> carry=1 that cycle, next pc=0x0000; same with load=1 -> carry=0, pc=load_addr.
REQ-041 SHALL verify: pc=0x10F0, branch offset=0x20 -> pc=0x1110, page_cross=1 one cycle; pc=0x1110, offset=0xF0 -> pc=0x1100, page_cross=0.
REQ-042 SHALL verify: 4 calls from pc 0x0100,0x0200,0x0300,0x0400 -> stack_full=1; 5th call -> pc=call_addr, overflow=1; 4 rets -> pc 0x0400,0x0300,0x0200,0x0100, stack_empty=1.
REQ-043 SHALL verify: ret while empty at pc=0x1234 -> pc stays 0x1234, underflow=1; clear_err -> underflow=0.
REQ-044 SHALL verify: load and call and branch asserted together -> pc=load_addr, sp unchanged; reset_n pulsed low mid-cycle -> pc=RESET_ADDR immediately, sp=0.

Source files
------------

// File: rtl/pc_unit.sv
// Program counter with priority-selected load/call/ret/branch/increment,
// a small return-address stack, page-cross detection and sticky stack errors.
module pc_unit #(
  parameter int          WIDTH       = 16,
  parameter int unsigned RESET_ADDR  = 0,
  parameter int          STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       inc,
  input  logic             load,
  input  logic [WIDTH-1:0] load_addr,
  input  logic             call,
  input  logic [WIDTH-1:0] call_addr,
  input  logic             ret,
  input  logic             branch,
  input  logic [7:0]       offset,
  input  logic             clear_err,
  output logic [WIDTH-1:0] pc,
  output logic             carry,
  output logic             page_cross,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             overflow,
  output logic             underflow
);

  localparam int               IDX_W    = $clog2(STACK_DEPTH);
  localparam int               SP_W     = IDX_W + 1;
  localparam logic [WIDTH-1:0] RESET_PC = RESET_ADDR[WIDTH-1:0];
  localparam logic [SP_W-1:0]  FULL_SP  = SP_W'(STACK_DEPTH);

  logic [WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [SP_W-1:0]  sp;
  logic [SP_W-1:0]  sp_minus1;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  logic             sel_load;
  logic             sel_call;
  logic             sel_ret;
  logic             sel_branch;
  logic             sel_inc;
  logic             push_ok;
  logic             pop_ok;
  logic [WIDTH:0]   inc_sum;
  logic [WIDTH-1:0] offset_ext;
  logic [WIDTH-1:0] branch_target;
  logic             page_cross_next;
  logic [WIDTH-1:0] pc_next;

  // Exactly one operation wins each cycle; masked requests have no side effects.
  assign sel_load   = load;
  assign sel_call   = ~load & call;
  assign sel_ret    = ~load & ~call & ret;
  assign sel_branch = ~load & ~call & ~ret & branch;
  assign sel_inc    = ~(load | call | ret | branch);

  assign stack_empty = (sp == '0);
  assign stack_full  = (sp == FULL_SP);
  assign push_ok     = sel_call & ~stack_full;
  assign pop_ok      = sel_ret & ~stack_empty;

  assign sp_minus1 = sp - SP_W'(1);
  assign wr_idx    = sp[IDX_W-1:0];
  assign rd_idx    = sp_minus1[IDX_W-1:0];

  // One extra bit on the increment sum exposes the wrap for carry.
  assign inc_sum = {1'b0, pc} + (WIDTH + 1)'(inc);
  assign carry   = sel_inc & inc_sum[WIDTH];

  // Sign-extend the branch displacement without a zero-width replication at WIDTH=8.
  always_comb begin
    offset_ext      = offset[7] ? '1 : '0;
    offset_ext[7:0] = offset;
  end

  assign branch_target   = pc + offset_ext;
  assign page_cross_next = sel_branch & ((branch_target >> 8) != (pc >> 8));

  // Next program counter from the winning operation.
  always_comb begin
    pc_next = pc;
    if (sel_load) begin
      pc_next = load_addr;
    end else if (sel_call) begin
      pc_next = call_addr;
    end else if (sel_ret) begin
      if (!stack_empty) begin
        pc_next = stack_mem[rd_idx];
      end
    end else if (sel_branch) begin
      pc_next = branch_target;
    end else begin
      pc_next = inc_sum[WIDTH-1:0];
    end
  end

  // Counter, stack pointer and status flags; error set wins over clear_err.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc         <= RESET_PC;
      sp         <= '0;
      page_cross <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      pc         <= pc_next;
      page_cross <= page_cross_next;
      if (push_ok) begin
        sp <= sp + SP_W'(1);
      end else if (pop_ok) begin
        sp <= sp_minus1;
      end
      if (sel_call && stack_full) begin
        overflow <= 1'b1;
      end else if (clear_err) begin
        overflow <= 1'b0;
      end
      if (sel_ret && stack_empty) begin
        underflow <= 1'b1;
      end else if (clear_err) begin
        underflow <= 1'b0;
      end
    end
  end

  // Return-address storage; entries above sp are don't-care so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      stack_mem[wr_idx] <= pc;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a driver feeds stimulus and queues the
// expected response from a queue-based reference model; a monitor pops and
// compares once per cycle.
module tb_pc_unit;

  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int RST   = 0;

  logic          clk;
  logic          reset_n;
  logic [1:0]    inc;
  logic          load;
  logic [W-1:0]  load_addr;
  logic          call;
  logic [W-1:0]  call_addr;
  logic          ret;
  logic          branch;
  logic [7:0]    offset;
  logic          clear_err;
  logic [W-1:0]  pc;
  logic          carry;
  logic          page_cross;
  logic          stack_empty;
  logic          stack_full;
  logic          overflow;
  logic          underflow;

  typedef struct {
    string      name;
    logic [W-1:0] pc;
    logic       pcx;
    logic       empty;
    logic       full;
    logic       ov;
    logic       uf;
    logic       carry;
  } exp_t;

  exp_t exp_q[$];

  int checks;
  int failures;

  int m_pc;
  int m_stack[$];
  bit m_ov;
  bit m_uf;

  pc_unit #(
    .WIDTH(W),
    .RESET_ADDR(RST),
    .STACK_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .inc(inc),
    .load(load),
    .load_addr(load_addr),
    .call(call),
    .call_addr(call_addr),
    .ret(ret),
    .branch(branch),
    .offset(offset),
    .clear_err(clear_err),
    .pc(pc),
    .carry(carry),
    .page_cross(page_cross),
    .stack_empty(stack_empty),
    .stack_full(stack_full),
    .overflow(overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    m_pc = RST;
    m_stack.delete();
    m_ov = 1'b0;
    m_uf = 1'b0;
  endtask

  task automatic zeroInputs();
    inc       = 2'd0;
    load      = 1'b0;
    load_addr = '0;
    call      = 1'b0;
    call_addr = '0;
    ret       = 1'b0;
    branch    = 1'b0;
    offset    = '0;
    clear_err = 1'b0;
  endtask

  // Drive one cycle of inputs and queue what the model says should follow.
  task automatic applyStimulus(input string name, input bit ld, input int la, input bit cl, input int ca,
                               input bit rt, input bit br, input int off, input int inc_v, input bit ce);
    exp_t e;
    bit   set_ov;
    bit   set_uf;
    int   o;
    int   nxt;
    @(negedge clk);
    load      = ld;
    load_addr = la[W-1:0];
    call      = cl;
    call_addr = ca[W-1:0];
    ret       = rt;
    branch    = br;
    offset    = off[7:0];
    inc       = inc_v[1:0];
    clear_err = ce;

    e.name  = name;
    e.carry = !(ld || cl || rt || br) && ((m_pc + inc_v) > 32'hFFFF);
    e.pcx   = 1'b0;
    set_ov  = 1'b0;
    set_uf  = 1'b0;
    if (ld) begin
      m_pc = la & 32'hFFFF;
    end else if (cl) begin
      if (m_stack.size() < DEPTH) m_stack.push_back(m_pc);
      else set_ov = 1'b1;
      m_pc = ca & 32'hFFFF;
    end else if (rt) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else set_uf = 1'b1;
    end else if (br) begin
      o = off & 255;
      if (o > 127) o = o - 256;
      nxt   = (m_pc + o) & 32'hFFFF;
      e.pcx = (nxt / 256) != (m_pc / 256);
      m_pc  = nxt;
    end else begin
      m_pc = (m_pc + inc_v) & 32'hFFFF;
    end
    m_ov = set_ov ? 1'b1 : (ce ? 1'b0 : m_ov);
    m_uf = set_uf ? 1'b1 : (ce ? 1'b0 : m_uf);

    e.pc    = m_pc[W-1:0];
    e.empty = (m_stack.size() == 0);
    e.full  = (m_stack.size() == DEPTH);
    e.ov    = m_ov;
    e.uf    = m_uf;
    exp_q.push_back(e);
  endtask

  // Wait for the monitor to consume everything queued so far.
  task automatic drainQueue();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 20) begin
      @(posedge clk);
      w++;
    end
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain pending=%0d expected=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Pulse reset low in the middle of a cycle and check the asynchronous response.
  task automatic resetPulse();
    drainQueue();
    @(negedge clk);
    zeroInputs();
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_pulse/pc", 32'(pc), 32'(RST));
    checkOutput("rst_pulse/empty", 32'(stack_empty), 32'd1);
    checkOutput("rst_pulse/full", 32'(stack_full), 32'd0);
    checkOutput("rst_pulse/pcx", 32'(page_cross), 32'd0);
    checkOutput("rst_pulse/ov", 32'(overflow), 32'd0);
    checkOutput("rst_pulse/uf", 32'(underflow), 32'd0);
    @(negedge clk);
    #3 reset_n = 1'b1;
    modelReset();
  endtask

  // Monitor: carry is checked while the inputs are stable, state just after the edge.
  initial begin
    exp_t e;
    forever begin
      wait (exp_q.size() != 0);
      #2;
      checkOutput({exp_q[0].name, "/carry"}, 32'(carry), 32'(exp_q[0].carry));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checkOutput({e.name, "/pc"}, 32'(pc), 32'(e.pc));
      checkOutput({e.name, "/pcx"}, 32'(page_cross), 32'(e.pcx));
      checkOutput({e.name, "/empty"}, 32'(stack_empty), 32'(e.empty));
      checkOutput({e.name, "/full"}, 32'(stack_full), 32'(e.full));
      checkOutput({e.name, "/ov"}, 32'(overflow), 32'(e.ov));
      checkOutput({e.name, "/uf"}, 32'(underflow), 32'(e.uf));
    end
  end

  // Main sequence: directed scenarios followed by random traffic.
  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    zeroInputs();
    modelReset();
    #1;
    checkOutput("reset/pc", 32'(pc), 32'(RST));
    checkOutput("reset/empty", 32'(stack_empty), 32'd1);
    checkOutput("reset/pcx", 32'(page_cross), 32'd0);
    checkOutput("reset/ov", 32'(overflow), 32'd0);
    checkOutput("reset/uf", 32'(underflow), 32'd0);
    #11 reset_n = 1'b1;

    $display("[TB] increment sequence");
    for (int i = 0; i < 3; i++) applyStimulus("inc1", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus("inc3", 0, 0, 0, 0, 0, 0, 0, 3, 0);

    $display("[TB] carry and wrap");
    applyStimulus("ld_fffe", 1, 16'hFFFE, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("wrap", 0, 0, 0, 0, 0, 0, 0, 2, 0);
    applyStimulus("ld_fffe2", 1, 16'hFFFE, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("ld_inc", 1, 16'h0ABC, 0, 0, 0, 0, 0, 2, 0);

    $display("[TB] branch page crossing");
    applyStimulus("ld_10f0", 1, 16'h10F0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("br_fwd", 0, 0, 0, 0, 0, 1, 8'h20, 0, 0);
    applyStimulus("br_back", 0, 0, 0, 0, 0, 1, 8'hF0, 0, 0);
    applyStimulus("br_idle", 0, 0, 0, 0, 0, 0, 0, 1, 0);

    $display("[TB] call stack fill and drain");
    applyStimulus("ld_0100", 1, 16'h0100, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 2; i <= 5; i++) applyStimulus("call", 0, 0, 1, i * 16'h0100, 0, 0, 0, 0, 0);
    applyStimulus("call_full", 0, 0, 1, 16'h0900, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus("ret", 0, 0, 0, 0, 1, 0, 0, 0, 0);
    applyStimulus("clr_ov", 0, 0, 0, 0, 0, 0, 0, 0, 1);

    $display("[TB] underflow");
    applyStimulus("ld_1234", 1, 16'h1234, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("ret_empty", 0, 0, 0, 0, 1, 0, 0, 0, 0);
    applyStimulus("clr_uf", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus("ret_clr", 0, 0, 0, 0, 1, 0, 0, 0, 1);

    $display("[TB] priority and mid-cycle reset");
    applyStimulus("call_one", 0, 0, 1, 16'h2000, 0, 0, 0, 0, 0);
    applyStimulus("ld_call_br", 1, 16'h4321, 1, 16'h5555, 0, 1, 8'h10, 0, 0);
    applyStimulus("call_ret", 0, 0, 1, 16'h6000, 1, 0, 0, 0, 0);
    resetPulse();
    applyStimulus("post_rst", 0, 0, 0, 0, 0, 0, 0, 2, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      applyStimulus("rand",
                    $urandom_range(0, 9) == 0, int'($urandom_range(0, 16'hFFFF)),
                    $urandom_range(0, 4) == 0, int'($urandom_range(0, 16'hFFFF)),
                    $urandom_range(0, 4) == 0,
                    $urandom_range(0, 4) == 0, int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 3)),
                    $urandom_range(0, 9) == 0);
    end

    drainQueue();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
